// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for the single synchronous RAM port.
// Bounded bursts; one access per cycle; acks return two cycles after grant.
module mem_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_ack,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_ack,
  output logic [DW-1:0] r1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic [DW-1:0] mem_dout,
  input  logic [DW-1:0] mem_din,
  output logic          owner
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state;
  logic [CW-1:0] burst_cnt;
  logic          last;

  logic          any_gnt;
  logic          gnt_port;
  logic          same_owner;
  logic          burst_open;

  logic          stage1_valid;
  logic          stage1_port;
  logic          ack_we;

  assign burst_open = (burst_cnt < CW'(MAX_BURST));

  always_comb begin
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    case (state)
      IDLE: begin
        if (r0_req && r1_req) begin
          r0_gnt = last;
          r1_gnt = !last;
        end else begin
          r0_gnt = r0_req;
          r1_gnt = r1_req;
        end
      end
      OWN0: begin
        if (r0_req && (!r1_req || burst_open)) r0_gnt = 1'b1;
        else if (r1_req)                       r1_gnt = 1'b1;
      end
      OWN1: begin
        if (r1_req && (!r0_req || burst_open)) r1_gnt = 1'b1;
        else if (r0_req)                       r0_gnt = 1'b1;
      end
      default: ;
    endcase
  end

  assign any_gnt    = r0_gnt | r1_gnt;
  assign gnt_port   = r1_gnt;
  assign same_owner = (state == OWN0 && r0_gnt) || (state == OWN1 && r1_gnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
      last      <= 1'b1;
      owner     <= 1'b0;
    end else if (any_gnt) begin
      owner <= gnt_port;
      state <= gnt_port ? OWN1 : OWN0;
      if (same_owner) begin
        if (burst_open) burst_cnt <= burst_cnt + CW'(1);
      end else begin
        burst_cnt <= CW'(1);
        // Leaving an owned burst records who just had it; IDLE grants keep last.
        if (state != IDLE) last <= (state == OWN1);
      end
    end else if (state != IDLE) begin
      state <= IDLE;
      last  <= (state == OWN1);
    end
  end

  // Stage 1 drives the RAM; stage 2 is the ack cycle where read data arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr     <= '0;
      mem_wr       <= 1'b0;
      mem_dout     <= '0;
      stage1_valid <= 1'b0;
      stage1_port  <= 1'b0;
      r0_ack       <= 1'b0;
      r1_ack       <= 1'b0;
      ack_we       <= 1'b0;
    end else begin
      stage1_valid <= any_gnt;
      stage1_port  <= gnt_port;
      mem_wr       <= any_gnt && (gnt_port ? r1_we : r0_we);
      if (any_gnt) begin
        mem_addr <= gnt_port ? r1_addr  : r0_addr;
        mem_dout <= gnt_port ? r1_wdata : r0_wdata;
      end
      r0_ack <= stage1_valid && !stage1_port;
      r1_ack <= stage1_valid &&  stage1_port;
      ack_we <= mem_wr;
    end
  end

  assign r0_rdata = (r0_ack && !ack_we) ? mem_din : '0;
  assign r1_rdata = (r1_ack && !ack_we) ? mem_din : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous RAM model.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [15:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_gnt, r0_ack, r1_gnt, r1_ack;
  logic [15:0] r0_rdata, r1_rdata;
  logic [15:0] mem_addr, mem_dout, mem_din;
  logic        mem_wr;
  logic        owner;

  logic [15:0] ram [0:255];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [15:0] pl_data;

  int n_assert;
  int n_fail;

  mem_arbiter #(.AW(16), .DW(16), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
    .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first synchronous RAM; preload port used only during reset.
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mem_wr) ram[mem_addr[7:0]] <= mem_dout;
    mem_din <= ram[mem_addr[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int g_cur, g_prev1, g_prev2;
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;

    tick();
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wr",   32'(mem_wr), 0);
    check("rst_mem_dout", 32'(mem_dout), 0);
    check("rst_r0_ack",   32'(r0_ack), 0);
    check("rst_r1_ack",   32'(r1_ack), 0);
    check("rst_owner",    32'(owner), 0);

    pl_en = 1'b1; pl_addr = 8'h10; pl_data = 16'hBEEF; tick();
    pl_addr = 8'h30; pl_data = 16'hA0A0; tick();
    pl_addr = 8'h40; pl_data = 16'hB1B1; tick();
    pl_en = 1'b0;
    rst = 1'b0;
    tick();

    // Test 1: single r0 read
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 16'h0010; #1;
    check("t1_r0_gnt", 32'(r0_gnt), 1);
    check("t1_r1_gnt", 32'(r1_gnt), 0);
    tick(); r0_req = 1'b0; #1;
    check("t1_mem_addr", 32'(mem_addr), 32'h10);
    check("t1_mem_wr",   32'(mem_wr), 0);
    check("t1_ack_early", 32'(r0_ack), 0);
    tick(); #1;
    check("t1_r0_ack",   32'(r0_ack), 1);
    check("t1_r0_rdata", 32'(r0_rdata), 32'hBEEF);
    check("t1_r1_ack",   32'(r1_ack), 0);
    tick(); #1;
    check("t1_ack_gone",   32'(r0_ack), 0);
    check("t1_rdata_zero", 32'(r0_rdata), 0);

    // Test 2: r1 write then read-back of the same address
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 16'h0020; r1_wdata = 16'h1234; #1;
    check("t2_w_gnt", 32'(r1_gnt), 1);
    tick(); r1_we = 1'b0; #1;
    check("t2_r_gnt",    32'(r1_gnt), 1);
    check("t2_mem_wr",   32'(mem_wr), 1);
    check("t2_mem_addr", 32'(mem_addr), 32'h20);
    check("t2_mem_dout", 32'(mem_dout), 32'h1234);
    tick(); r1_req = 1'b0; #1;
    check("t2_mem_wr_off", 32'(mem_wr), 0);
    check("t2_w_ack",      32'(r1_ack), 1);
    check("t2_w_rdata",    32'(r1_rdata), 0);
    check("t2_owner",      32'(owner), 1);
    tick(); #1;
    check("t2_r_ack",   32'(r1_ack), 1);
    check("t2_r_rdata", 32'(r1_rdata), 32'h1234);
    check("t2_r0_ack",  32'(r0_ack), 0);
    tick(); #1;
    check("t2_ack_gone", 32'(r1_ack), 0);

    // Test 3: both requesting continuously from reset
    rst = 1'b1; tick(); rst = 1'b0;
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 16'h0030;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 16'h0040;
    for (int i = 0; i < 12; i++) begin
      #1;
      g_cur   = (i / 4) % 2;
      g_prev1 = (i >= 1) ? ((i - 1) / 4) % 2 : 0;
      g_prev2 = (i >= 2) ? ((i - 2) / 4) % 2 : 0;
      check($sformatf("t3_r0_gnt_%0d", i), 32'(r0_gnt), (g_cur == 0) ? 1 : 0);
      check($sformatf("t3_r1_gnt_%0d", i), 32'(r1_gnt), (g_cur == 1) ? 1 : 0);
      check($sformatf("t3_owner_%0d", i),  32'(owner), g_prev1);
      check($sformatf("t3_r0_ack_%0d", i), 32'(r0_ack), (i >= 2 && g_prev2 == 0) ? 1 : 0);
      check($sformatf("t3_r1_ack_%0d", i), 32'(r1_ack), (i >= 2 && g_prev2 == 1) ? 1 : 0);
      check($sformatf("t3_r0_rdata_%0d", i), 32'(r0_rdata), (i >= 2 && g_prev2 == 0) ? 32'hA0A0 : 0);
      check($sformatf("t3_r1_rdata_%0d", i), 32'(r1_rdata), (i >= 2 && g_prev2 == 1) ? 32'hB1B1 : 0);
      tick();
    end
    r0_req = 1'b0; r1_req = 1'b0;
    tick(); tick(); tick();

    // Test 4: r0 alone for 10 grants, then r1 joins
    r0_req = 1'b1; r0_addr = 16'h0030;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("t4_r0_gnt_%0d", i), 32'(r0_gnt), 1);
      check($sformatf("t4_r1_gnt_%0d", i), 32'(r1_gnt), 0);
      tick();
    end
    r1_req = 1'b1; r1_addr = 16'h0040; #1;
    check("t4_switch_r1", 32'(r1_gnt), 1);
    check("t4_switch_r0", 32'(r0_gnt), 0);
    tick(); #1;
    check("t4_r1_keeps", 32'(r1_gnt), 1);
    tick(); r0_req = 1'b0; r1_req = 1'b0;
    tick(); tick(); tick();

    // Test 5: reset with two reads in flight
    r0_req = 1'b1; r0_addr = 16'h0010; #1;
    check("t5_r0_gnt", 32'(r0_gnt), 1);
    tick(); r0_req = 1'b0; r1_req = 1'b1; r1_addr = 16'h0020; #1;
    check("t5_r1_gnt", 32'(r1_gnt), 1);
    tick(); r1_req = 1'b0; #1;
    check("t5_pre_ack", 32'(r0_ack), 1);
    #1 rst = 1'b1;
    #1;
    check("t5_r0_ack_rst",   32'(r0_ack), 0);
    check("t5_r1_ack_rst",   32'(r1_ack), 0);
    check("t5_mem_wr_rst",   32'(mem_wr), 0);
    check("t5_mem_addr_rst", 32'(mem_addr), 0);
    check("t5_owner_rst",    32'(owner), 0);
    tick(); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("t5_no_r0_ack_%0d", k), 32'(r0_ack), 0);
      check($sformatf("t5_no_r1_ack_%0d", k), 32'(r1_ack), 0);
      tick();
    end
    r0_req = 1'b1; r1_req = 1'b1; #1;
    check("t5_tie_r0", 32'(r0_gnt), 1);
    check("t5_tie_r1", 32'(r1_gnt), 0);
    tick(); r0_req = 1'b0; r1_req = 1'b0;
    tick(); tick(); tick();

    // Test 6: r0 request withdrawn before grant while r1 owns
    r1_req = 1'b1; r1_addr = 16'h0020; #1;
    check("t6_r1_gnt0", 32'(r1_gnt), 1);
    tick(); r0_req = 1'b1; r0_we = 1'b0; r0_addr = 16'h0005; #1;
    check("t6_r0_wait", 32'(r0_gnt), 0);
    check("t6_r1_gnt1", 32'(r1_gnt), 1);
    tick(); r0_req = 1'b0; #1;
    check("t6_r0_dropped", 32'(r0_gnt), 0);
    tick(); r1_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("t6_no_ack_%0d", k),  32'(r0_ack), 0);
      check($sformatf("t6_no_addr_%0d", k), 32'(mem_addr != 16'h0005), 1);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
